ram_be: RTL
===========

// Module: ram_be
// PURPOSE
//  Next-generation on-chip data RAM: word-organised, byte-addressed, synchronous, single port.
//  Adds per-byte write strobes, a programmable wait-state latency and a misaligned-access error.
//  Drop-in successor on the core's Cs/We/Ack memory bus; the core holds a request until Ack.
// PARAMETERS
//  WORD_SIZE  4     bytes per word; power of two, >= 1
//  CAPACITY   1024  total bytes; power of two, multiple of WORD_SIZE
//  LATENCY    1     edges from request-sampling edge to Ack rise; 1..15
//  (local) ADDR_W = $clog2(CAPACITY), OFS_W = $clog2(WORD_SIZE)
// PORTS
//  Clk    in   1              clock, all state on posedge
//  Rst    in   1              asynchronous reset, active-high
//  Addr   in   ADDR_W         byte address; word index = Addr[ADDR_W-1:OFS_W]
//  Cs     in   1              request valid
//  We     in   1              1 = write, 0 = read
//  Be     in   WORD_SIZE      byte write strobes, bit i -> Wdata[8i+7:8i]
//  Wdata  in   8*WORD_SIZE    write data
//  Rdata  out  8*WORD_SIZE    read data, registered
//  Ack    out  1              one-cycle completion pulse
//  Err    out  1              misaligned access, valid only with Ack
// BEHAVIOUR
//  Reset: state IDLE, Ack=0, Err=0, Rdata=0, counter=0. Memory array not cleared (X at power-up).
//  FSM IDLE/BUSY/RESP:
//   IDLE: at edge E0 with Cs=1, latch Addr/We/Be/Wdata, cnt<=LATENCY-1, go BUSY. Cs=0: stay.
//   BUSY: cnt!=0 -> cnt-1. cnt==0 -> perform access at this edge, Ack<=1, go RESP.
//   RESP: Ack=1 (Err per access) for exactly one cycle; next edge Ack<=0, Err<=0, go IDLE unconditionally.
//  Ack rises after edge E0+LATENCY and falls after E0+LATENCY+1.
//  Minimum access period LATENCY+2 cycles.
//  Bus inputs ignored in BUSY/RESP; changes there never affect the latched access.
//  Cs still high in IDLE after RESP starts a new access. Core drops Cs during the Ack cycle.
//  Aligned write (Addr[OFS_W-1:0]==0): only lanes with Be[i]=1 updated. Be=0 -> Ack, no change. Rdata unchanged.
//  Aligned read: Rdata<=whole word at the access edge, independent of Be. Rdata holds until next aligned read.
//  Misaligned (offset bits !=0, any We): no memory write, Rdata unchanged, Err=1 with Ack.
//  Addr spans exactly CAPACITY: no out-of-range case.
//  Top word CAPACITY-WORD_SIZE is a normal access, no wrap logic.
//  Reset mid-operation (BUSY or RESP): latched access abandoned, no write, Ack/Err forced 0 immediately.
//  Memory contents written before reset are preserved.
//  WORD_SIZE=1: OFS_W=0, never misaligned, Be is 1 bit.
// TESTING
//  1 Defaults: write aaaaaaaa@0, bbbbbbbb@4, cccccccc@8, dddddddd@12, read back -> each Rdata matches.
//    Ack high exactly 1 cycle, rising 1 edge after sampling edge.
//  2 Strobes: write 11223344@8 Be=f, then aabbccdd@8 Be=0101b, read@8 -> 11bb33dd.
//    Write Be=0 -> Ack, word unchanged.
//  3 Misaligned: write ffffffff@2 -> Ack=1, Err=1. Read@0 -> prior value, Err=0.
//    Rdata unchanged across the error access.
//  4 LATENCY=4 instance: Ack rises exactly 4 edges after sampling edge.
//    Toggle Addr/Wdata/We during BUSY -> original access performed.
//  5 Async Rst pulse mid-BUSY of write 12345678@16: Ack/Err drop immediately, never pulse.
//    Read@16 after reset -> old contents.
//  6 Cs held high through Ack: second access sampled on first IDLE edge, period LATENCY+2.
//    Access at CAPACITY-WORD_SIZE reads/writes correctly.

Source files
------------

// File: rtl/ram_be.sv
// ram_be: byte-addressed single-port word RAM with byte strobes, programmable wait states
// and a misaligned-access error, answering on the Cs/We/Ack bus.
module ram_be #(
    parameter  int WORD_SIZE = 4,
    parameter  int CAPACITY  = 1024,
    parameter  int LATENCY   = 1,
    localparam int ADDR_W    = $clog2(CAPACITY),
    localparam int OFS_W     = $clog2(WORD_SIZE),
    localparam int DW        = 8 * WORD_SIZE
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Cs,
    input  logic              We,
    input  logic [WORD_SIZE-1:0] Be,
    input  logic [DW-1:0]     Wdata,
    output logic [DW-1:0]     Rdata,
    output logic              Ack,
    output logic              Err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(WORD_SIZE - 1);

    state_t state, state_d;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic we_q;
    logic [WORD_SIZE-1:0] be_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] mem [CAPACITY/WORD_SIZE];
    logic start, fire, mis;

    assign start = (state == IDLE) && Cs;
    assign fire  = (state == BUSY) && (cnt == 4'd0);
    // the offset mask is zero when WORD_SIZE is 1, so such accesses are never misaligned
    assign mis   = |(addr_q & OFS_MASK);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = Cs ? BUSY : IDLE;
            BUSY:    state_d = (cnt == 4'd0) ? RESP : BUSY;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            Ack   <= 1'b0;
            Err   <= 1'b0;
            Rdata <= '0;
        end else begin
            state <= state_d;
            cnt   <= start ? 4'(LATENCY - 1) : (state == BUSY && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            Ack   <= fire;
            Err   <= fire && mis;
            if (fire && !we_q && !mis) Rdata <= mem[addr_q[ADDR_W-1:OFS_W]];
        end
    end

    // request latch and array carry no reset: contents survive Rst, and writes only fire from BUSY
    always_ff @(posedge Clk) begin
        if (start) begin
            addr_q  <= Addr;
            we_q    <= We;
            be_q    <= Be;
            wdata_q <= Wdata;
        end
        if (fire && we_q && !mis)
            for (int i = 0; i < WORD_SIZE; i++)
                if (be_q[i]) mem[addr_q[ADDR_W-1:OFS_W]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule
